// File: rtl/uart_rx_bram_loader.sv
// UART 8N1 receiver that streams bytes sequentially into a BRAM write port.
// Define UART_RX_PARITY_EN to receive 8E1 frames and discard bytes whose parity fails.
module uart_rx_bram_loader #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 9600,
  parameter int ADDR_W    = 16,
  parameter int NUM_BYTES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              arm,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_din,
  output logic [ADDR_W:0]   byte_count,
  output logic              loading,
  output logic              load_complete,
  output logic              frame_err
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0]  HALF_C = CNT_W'(CPB / 2 - 1);
  localparam logic [ADDR_W:0]   LAST_C = (ADDR_W + 1)'(NUM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WRITE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             rx_meta, rxs, rxs_d;
  logic             set_ferr;
  logic             tick;
  logic [ADDR_W:0]  count_inc;
`ifdef UART_RX_PARITY_EN
  logic             par_bad, par_bad_n;
`else
  logic             par_bad;
  assign par_bad = 1'b0;
`endif

  // Synchroniser plus one delay stage for falling-edge detection; idle line is 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  assign tick = (cnt == FULL_C);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    set_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
`endif
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (rxs_d && !rxs) state_n = S_START;
      end
      S_START: begin
        if (cnt == HALF_C) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_n     = '0;
          shreg_n   = {rxs, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state_n = S_PARITY;
`else
          if (bit_idx == 3'd7) state_n = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          cnt_n     = '0;
          par_bad_n = ^{shreg, rxs};
          set_ferr  = ^{shreg, rxs};
          state_n   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          cnt_n    = '0;
          set_ferr = !rxs;
          state_n  = (rxs && !par_bad) ? S_WRITE : S_IDLE;
        end
      end
      S_WRITE: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  assign count_inc = byte_count + 1'b1;

  // The next free address equals byte_count, so bram_addr keeps the last written address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bram_we       <= 1'b0;
      bram_addr     <= '0;
      bram_din      <= '0;
      byte_count    <= '0;
      loading       <= 1'b0;
      load_complete <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      if (arm) begin
        loading       <= 1'b1;
        bram_addr     <= '0;
        byte_count    <= '0;
        load_complete <= 1'b0;
        frame_err     <= 1'b0;
      end else begin
        if (set_ferr) frame_err <= 1'b1;
        if (state == S_WRITE && loading) begin
          bram_we    <= 1'b1;
          bram_din   <= shreg;
          bram_addr  <= byte_count[ADDR_W-1:0];
          byte_count <= count_inc;
          if (count_inc == LAST_C) begin
            load_complete <= 1'b1;
            loading       <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_bram_loader.sv
// Scoreboard bench for uart_rx_bram_loader: 16 clks/bit, 4-byte loads.
module tb_uart_rx_bram_loader;

`ifdef UART_RX_PARITY_EN
  localparam int unsigned PAR_CLKS = 16;
`else
  localparam int unsigned PAR_CLKS = 0;
`endif
  localparam int unsigned WR_LAT = 156 + PAR_CLKS;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic        arm = 1'b0;
  logic        bram_we;
  logic [15:0] bram_addr;
  logic [7:0]  bram_din;
  logic [16:0] byte_count;
  logic        loading, load_complete, frame_err;

  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int unsigned at;
  } exp_t;
  exp_t q[$];

  uart_rx_bram_loader #(
    .CLK_FREQ(160), .BAUD(10), .ADDR_W(16), .NUM_BYTES(4)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .arm(arm),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .byte_count(byte_count), .loading(loading),
    .load_complete(load_complete), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (bram_we !== 1'b0) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got we=%b addr=%0h din=%0h at cycle %0d, required no write",
                 bram_we, bram_addr, bram_din, cyc);
      end else begin
        e = q.pop_front();
        if (bram_addr !== e.addr || bram_din !== e.data || cyc != e.at) begin
          miscompares++;
          $display("FAIL write: got addr=%0h din=%0h cycle=%0d, required addr=%0h din=%0h cycle=%0d",
                   bram_addr, bram_din, cyc, e.addr, e.data, e.at);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic check_status(input int unsigned cnt, input logic ld, input logic cmp, input logic fe);
    @(negedge clk);
    check("byte_count", 32'(byte_count), 32'(cnt));
    check("loading", 32'(loading), 32'(ld));
    check("load_complete", 32'(load_complete), 32'(cmp));
    check("frame_err", 32'(frame_err), 32'(fe));
  endtask

  task automatic pulse_arm();
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Stop-bit index 10 lines up with the WRITE cycle, so collide pulses arm there.
  task automatic send_byte(input logic [7:0] d, input logic stop_val, input logic par_flip,
                           input logic expect_wr, input logic [15:0] exp_addr, input logic collide);
    int unsigned c0;
    exp_t e;
    @(negedge clk);
    c0 = cyc;
    if (expect_wr) begin
      e.addr = exp_addr;
      e.data = d;
      e.at   = c0 + WR_LAT;
      q.push_back(e);
    end
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (16) @(negedge clk);
`else
    if (par_flip) rx = 1'b1;
`endif
    rx = stop_val;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      arm = collide && (i == 10);
    end
    rx = 1'b1;
  endtask

  initial begin
    idle(3);
    check("reset_we", 32'(bram_we), 32'd0);
    check("reset_addr", 32'(bram_addr), 32'd0);
    check_status(0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    idle(3);

    pulse_arm();
    send_byte(8'hA5, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0);
    check_status(1, 1'b1, 1'b0, 1'b0);

    pulse_arm();
    send_byte(8'h01, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0);
    send_byte(8'h03, 1'b1, 1'b0, 1'b1, 16'd2, 1'b0);
    send_byte(8'h04, 1'b1, 1'b0, 1'b1, 16'd3, 1'b0);
    check_status(4, 1'b0, 1'b1, 1'b0);
    send_byte(8'h55, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    check_status(4, 1'b0, 1'b1, 1'b0);
    check("addr_hold", 32'(bram_addr), 32'd3);

    pulse_arm();
    send_byte(8'h3C, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    check_status(0, 1'b1, 1'b0, 1'b1);
    idle(4);
    send_byte(8'h77, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0);
    check_status(1, 1'b1, 1'b0, 1'b1);

    pulse_arm();
    @(negedge clk) rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(30);
    check_status(0, 1'b1, 1'b0, 1'b0);

    send_byte(8'h11, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0);
    check_status(1, 1'b1, 1'b0, 1'b0);
    send_byte(8'h99, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    check_status(0, 1'b1, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    pulse_arm();
    send_byte(8'h0F, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0);
    check_status(1, 1'b1, 1'b0, 1'b0);
    send_byte(8'h0F, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
    check_status(1, 1'b1, 1'b0, 1'b1);
`endif

    idle(20);
    check("pending_writes", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
